// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier: state
// encoding, default operand width and the iteration-counter width helper.
package mul_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold 0..WIDTH-1; a one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int width);
    if (width <= 1) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/mul_step_datapath.sv
// Iteration datapath: accumulator, shifted multiplicand/multiplier and counter.
// SHIFT_MUL_EARLY_EXIT_EN enables the "remaining multiplier bits are zero" flag.
module mul_step_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [CW-1:0]      count,
  output logic               mplier_zero
);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      count_r;
  logic [2*WIDTH-1:0] acc_next_s;

  // Conditional add of the current multiplicand weight.
  always_comb begin
    acc_next_s = acc_r;
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Operand capture and one-bit-per-cycle iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (load) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
      count_r  <= {CW{1'b0}};
    end else if (step) begin
      acc_r    <= acc_next_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      count_r  <= count_r + CW'(1);
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      count_r  <= count_r;
    end
  end

  assign acc_next = acc_next_s;
  assign count    = count_r;

`ifdef SHIFT_MUL_EARLY_EXIT_EN
  // High when this step consumes the last set multiplier bit.
  assign mplier_zero = ((mplier_r >> 1) == {WIDTH{1'b0}});
`else
  assign mplier_zero = 1'b0;
`endif

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier feeding the 8-bit register block.
// Optional SHIFT_MUL_EARLY_EXIT_EN ends the iteration once the multiplier is exhausted.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   d_out,
  output logic               ovf
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state_r, state_s;
  logic               load_s, step_s, finish_s, cap_s;
  logic [2*WIDTH-1:0] cap_val_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [CW-1:0]      count_s;
  logic               mplier_zero_s;
  logic               busy_r, done_r, ovf_r;
  logic [2*WIDTH-1:0] product_r;

  mul_step_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .reset       (reset),
    .load        (load_s),
    .step        (step_s),
    .a           (a),
    .b           (b),
    .acc_next    (acc_next_s),
    .count       (count_s),
    .mplier_zero (mplier_zero_s)
  );

  assign finish_s = (count_s == CW'(WIDTH - 1)) | mplier_zero_s;

  // Next-state, datapath controls and result capture.
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    step_s    = 1'b0;
    cap_s     = 1'b0;
    cap_val_s = {(2*WIDTH){1'b0}};
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s = 1'b1;
`ifdef SHIFT_MUL_EARLY_EXIT_EN
          if (b == {WIDTH{1'b0}}) begin
            state_s = DONE;
            cap_s   = 1'b1;
          end else begin
            state_s = RUN;
          end
`else
          state_s = RUN;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (finish_s) begin
          state_s   = DONE;
          cap_s     = 1'b1;
          cap_val_s = acc_next_s;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; product/ovf change on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {(2*WIDTH){1'b0}};
      ovf_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
      if (cap_s) begin
        product_r <= cap_val_s;
        ovf_r     <= |cap_val_s[2*WIDTH-1:WIDTH];
      end else begin
        product_r <= product_r;
        ovf_r     <= ovf_r;
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;
  assign d_out   = product_r[WIDTH-1:0];
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (WIDTH=8); expected
// latencies follow SHIFT_MUL_EARLY_EXIT_EN when it is defined.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done, ovf;
  logic [15:0] product;
  logic [7:0]  d_out;
  logic [7:0]  reg_q;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SHIFT_MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  shift_add_multiplier #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .d_out   (d_out),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // Model of the downstream 8-bit register (load <= done, d_in <= d_out).
  always @(posedge clk) begin
    if (reset) reg_q <= 8'd0;
    else if (done) reg_q <= d_out;
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    logic        ovf;
    int          lat_def;
    int          lat_early;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at E0+#1; returns cycle index of done (1 = cycle after E0) and busy count.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    while (!done && lat < 30) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue(input logic [7:0] av, input logic [7:0] bv);
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = 8'hA5; b = 8'h5A;
  endtask

  task automatic run_check(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic [15:0] ep, input logic eo, input int el);
    int lat, bn;
    issue(av, bv);
    wait_done(lat, bn);
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " latency"}, lat, el);
    chk({tag, " busy cycles"}, bn, el - 1);
    chk({tag, " product"}, product, ep);
    chk({tag, " d_out"}, d_out, ep[7:0]);
    chk({tag, " ovf"}, ovf, eo);
    @(posedge clk); #1;
    chk({tag, " done single"}, done, 1'b0);
    chk({tag, " reg load"}, reg_q, ep[7:0]);
  endtask

  initial begin
    int lat, bn, pulses, first, c;
    logic [15:0] seen;

    vecs[0] = '{8'd13,  8'd11,  16'h008F, 1'b0, 9, 5};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01, 1'b1, 9, 9};
    vecs[2] = '{8'd1,   8'd1,   16'h0001, 1'b0, 9, 2};
    vecs[3] = '{8'd128, 8'd2,   16'h0100, 1'b1, 9, 3};
    vecs[4] = '{8'd9,   8'd3,   16'h001B, 1'b0, 9, 3};
    vecs[5] = '{8'd9,   8'd0,   16'h0000, 1'b0, 9, 1};
    vecs[6] = '{8'd0,   8'd200, 16'h0000, 1'b0, 9, 9};
    vecs[7] = '{8'd100, 8'd37,  16'h0E74, 1'b1, 9, 7};

    reset = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset product", product, 16'h0000);
    chk("reset d_out", d_out, 8'h00);
    chk("reset ovf", ovf, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].ovf,
                EARLY ? vecs[i].lat_early : vecs[i].lat_def);
    end

    // start during RUN is ignored: 3x4 then a 7x7 pulse
    issue(8'd3, 8'd4);
    @(posedge clk); #1;
    start = 1'b1; a = 8'd7; b = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    c = 3; pulses = 0; first = 0; seen = 16'hFFFF;
    while (c < 24) begin
      if (done) begin
        pulses++;
        if (first == 0) begin first = c; seen = product; end
      end
      @(posedge clk); #1;
      c++;
    end
    chk("ignored start pulses", pulses, 1);
    chk("ignored start latency", first, EARLY ? 4 : 9);
    chk("ignored start product", seen, 16'd12);

    // reset in the middle of RUN aborts without a done pulse
    issue(8'd13, 8'd11);
    repeat (3) @(posedge clk);
    #1;
    chk("pre-abort busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort product", product, 16'h0000);
    chk("abort ovf", ovf, 1'b0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) pulses++;
      @(posedge clk); #1;
    end
    chk("abort quiet", pulses, 0);
    run_check("after abort 2x2", 8'd2, 8'd2, 16'd4, 1'b0, EARLY ? 3 : 9);

    // start held high across two back-to-back operations
    start = 1'b1; a = 8'd5; b = 8'd6;
    @(posedge clk); #1;
    a = 8'd6; b = 8'd7;
    wait_done(lat, bn);
    chk("held first latency", lat, EARLY ? 4 : 9);
    chk("held first product", product, 16'd30);
    @(posedge clk); #1;
    chk("held gap done", done, 1'b0);
    chk("held gap busy", busy, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("held second accepted", busy, 1'b1);
    wait_done(lat, bn);
    chk("held second latency", lat, EARLY ? 4 : 9);
    chk("held second product", product, 16'd42);
    @(posedge clk); #1;
    chk("held second single", done, 1'b0);
    chk("held second reg", reg_q, 8'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
